// File: rtl/bomb_code_entry.sv
// Keypad entry side of the bomb game: scans a 4x4 active-low keypad,
// debounces whole-frame key codes, collects a 4-digit BCD code and
// decides success, wrong-code failures and lockout.
module bomb_code_entry #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned DEBOUNCE  = 3,
  parameter logic [15:0] CODE      = 16'h2468,
  parameter int unsigned MAX_TRIES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        armed,
  input  logic        expired,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic        success,
  output logic        locked,
  output logic        fail,
  output logic [15:0] digits,
  output logic [2:0]  count,
  output logic [1:0]  tries_left
);

  localparam int unsigned      DIV_W      = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [2:0]       DEB        = 3'(DEBOUNCE);
  localparam logic [1:0]       TRIES_INIT = 2'(MAX_TRIES);

  typedef enum logic [1:0] {IDLE, ENTRY, SUCCESS, LOCKED} state_t;

  // Scan and debounce state
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [1:0]       hits_q, hits_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       last_q, last_d;
  logic [2:0]       stable_q, stable_d;
  logic             fired_q, fired_d;
  logic             press_q, press_d;
  logic [3:0]       press_code_q, press_code_d;

  // Entry state
  state_t           state_q, state_d;
  logic [15:0]      digits_q, digits_d;
  logic [2:0]       count_q, count_d;
  logic [1:0]       tries_q, tries_d;
  logic             success_q, success_d;
  logic             locked_q, locked_d;
  logic             fail_q, fail_d;

  logic [1:0]       slot_hits;
  logic [3:0]       slot_code;
  logic [2:0]       hit_sum;
  logic [1:0]       frame_hits;
  logic [3:0]       frame_code;

  // Row scan, per-frame key accumulation and frame-level debounce
  always_comb begin
    div_d        = div_q;
    row_idx_d    = row_idx_q;
    hits_d       = hits_q;
    code_d       = code_q;
    last_d       = last_q;
    stable_d     = stable_q;
    fired_d      = fired_q;
    press_d      = 1'b0;
    press_code_d = press_code_q;
    slot_hits    = 2'd0;
    slot_code    = 4'd0;

    for (int c = 0; c < 4; c++) begin
      if (!col[c]) begin
        if (slot_hits != 2'd2) slot_hits = slot_hits + 2'd1;
        slot_code = {row_idx_q, 2'(c)};
      end
    end
    hit_sum    = {1'b0, hits_q} + {1'b0, slot_hits};
    frame_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    frame_code = (slot_hits != 2'd0) ? slot_code : code_q;

    if (div_q == DIV_LAST) begin
      div_d     = '0;
      row_idx_d = row_idx_q + 2'd1;
      if (row_idx_q == 2'd3) begin
        hits_d = 2'd0;
        code_d = 4'd0;
        if (frame_hits == 2'd1) begin
          if (stable_q != 3'd0 && last_q == frame_code) begin
            if (stable_q != DEB) stable_d = stable_q + 3'd1;
          end else begin
            last_d   = frame_code;
            stable_d = 3'd1;
          end
          if (stable_d == DEB && !fired_q) begin
            press_d      = 1'b1;
            press_code_d = frame_code;
            fired_d      = 1'b1;
          end
        end else begin
          stable_d = 3'd0;
          fired_d  = 1'b0;
        end
      end else begin
        hits_d = frame_hits;
        code_d = frame_code;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Entry FSM: digit collection, code check, tries and lockout
  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    count_d   = count_q;
    tries_d   = tries_q;
    success_d = success_q;
    locked_d  = locked_q;
    fail_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (armed) state_d = ENTRY;
      end
      ENTRY: begin
        if (expired) begin
          locked_d = 1'b1;
          state_d  = LOCKED;
        end else if (!armed) begin
          state_d  = IDLE;
          digits_d = '0;
          count_d  = '0;
          tries_d  = TRIES_INIT;
        end else if (press_q) begin
          if (press_code_q <= 4'd9) begin
            if (count_q != 3'd4) begin
              digits_d = {digits_q[11:0], press_code_q};
              count_d  = count_q + 3'd1;
            end
          end else if (press_code_q == 4'd10) begin
            digits_d = '0;
            count_d  = '0;
          end else if (press_code_q == 4'd11 && count_q == 3'd4) begin
            if (digits_q == CODE) begin
              success_d = 1'b1;
              state_d   = SUCCESS;
            end else begin
              fail_d   = 1'b1;
              digits_d = '0;
              count_d  = '0;
              tries_d  = tries_q - 2'd1;
              if (tries_q == 2'd1) begin
                locked_d = 1'b1;
                state_d  = LOCKED;
              end
            end
          end
        end
      end
      SUCCESS, LOCKED: ;
      default: state_d = IDLE;
    endcase
  end

  // All state registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      row_idx_q    <= 2'd0;
      hits_q       <= 2'd0;
      code_q       <= 4'd0;
      last_q       <= 4'd0;
      stable_q     <= 3'd0;
      fired_q      <= 1'b0;
      press_q      <= 1'b0;
      press_code_q <= 4'd0;
      state_q      <= IDLE;
      digits_q     <= '0;
      count_q      <= 3'd0;
      tries_q      <= TRIES_INIT;
      success_q    <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      div_q        <= div_d;
      row_idx_q    <= row_idx_d;
      hits_q       <= hits_d;
      code_q       <= code_d;
      last_q       <= last_d;
      stable_q     <= stable_d;
      fired_q      <= fired_d;
      press_q      <= press_d;
      press_code_q <= press_code_d;
      state_q      <= state_d;
      digits_q     <= digits_d;
      count_q      <= count_d;
      tries_q      <= tries_d;
      success_q    <= success_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
    end
  end

  assign row        = ~(4'b0001 << row_idx_q);
  assign success    = success_q;
  assign locked     = locked_q;
  assign fail       = fail_q;
  assign digits     = digits_q;
  assign count      = count_q;
  assign tries_left = tries_q;

endmodule

// File: tb/tb_bomb_code_entry.sv
// Self-checking bench for bomb_code_entry: a keypad model drives col from
// the scanned rows, a behavioural model predicts every output each cycle,
// and literal checks pin the model at key points of each scenario.
module tb_bomb_code_entry;

  localparam int          SD     = 4;
  localparam int          DEB    = 3;
  localparam logic [15:0] SECRET = 16'h2468;
  localparam int          MAXT   = 3;
  localparam int          FRAME  = 4 * SD;

  localparam int M_IDLE    = 0;
  localparam int M_ENTRY   = 1;
  localparam int M_SUCCESS = 2;
  localparam int M_LOCKED  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        armed = 1'b0;
  logic        expired = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        success, locked, fail;
  logic [15:0] digits;
  logic [2:0]  count;
  logic [1:0]  tries_left;

  logic [15:0] keys = '0;
  bit          cmp_en = 1'b0;
  int          checks = 0;
  int          passed = 0;
  int          fail_seen = 0;

  // Model state: scan position, debounce history, entry contents
  int  m_k = 0;
  int  m_slot = 0;
  int  m_hits = 0;
  int  m_fcode = 0;
  int  m_dcnt = 0;
  int  m_dcode = 0;
  bit  m_fired = 1'b0;
  bit  m_pend = 1'b0;
  int  m_pcode = 0;
  int  m_mode = M_IDLE;
  int  m_q[$];
  int  e_tries = MAXT;
  bit  e_success = 1'b0;
  bit  e_locked = 1'b0;
  bit  e_fail = 1'b0;
  logic [3:0] exp_row;

  always #5 clk = ~clk;

  bomb_code_entry #(
    .SCAN_DIV(SD), .DEBOUNCE(DEB), .CODE(SECRET), .MAX_TRIES(MAXT)
  ) dut (
    .clk(clk), .rst(rst), .armed(armed), .expired(expired),
    .col(col), .row(row), .success(success), .locked(locked),
    .fail(fail), .digits(digits), .count(count), .tries_left(tries_left)
  );

  // Keypad: a held key pulls its column low while its row is driven low
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
  end

  function automatic logic [15:0] digitsOf();
    logic [15:0] v = '0;
    foreach (m_q[i]) v = {v[11:0], 4'(m_q[i])};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: frame results from held keys, debounce, entry rules
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k = 0; m_hits = 0; m_fcode = 0; m_dcnt = 0; m_dcode = 0;
      m_fired = 0; m_pend = 0; m_pcode = 0; m_mode = M_IDLE;
      m_q.delete(); e_tries = MAXT; e_success = 0; e_locked = 0; e_fail = 0;
    end else begin
      e_fail = 0;
      if (m_mode == M_IDLE) begin
        if (armed) m_mode = M_ENTRY;
      end else if (m_mode == M_ENTRY) begin
        if (expired) begin
          e_locked = 1; m_mode = M_LOCKED;
        end else if (!armed) begin
          m_mode = M_IDLE; m_q.delete(); e_tries = MAXT;
        end else if (m_pend) begin
          if (m_pcode <= 9) begin
            if (m_q.size() < 4) m_q.push_back(m_pcode);
          end else if (m_pcode == 10) begin
            m_q.delete();
          end else if (m_pcode == 11 && m_q.size() == 4) begin
            if (digitsOf() == SECRET) begin
              e_success = 1; m_mode = M_SUCCESS;
            end else begin
              e_fail = 1; m_q.delete(); e_tries--;
              if (e_tries == 0) begin e_locked = 1; m_mode = M_LOCKED; end
            end
          end
        end
      end
      m_pend = 0;
      if (m_k % SD == SD - 1) begin
        m_slot = (m_k / SD) % 4;
        for (int c = 0; c < 4; c++)
          if (keys[m_slot*4+c]) begin m_hits++; m_fcode = m_slot*4 + c; end
        if (m_slot == 3) begin
          if (m_hits == 1) begin
            if (m_dcnt > 0 && m_dcode == m_fcode) m_dcnt++;
            else begin m_dcode = m_fcode; m_dcnt = 1; end
            if (m_dcnt == DEB && !m_fired) begin
              m_pend = 1; m_pcode = m_fcode; m_fired = 1;
            end
          end else begin
            m_dcnt = 0; m_fired = 0;
          end
          m_hits = 0;
        end
      end
      m_k++;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (fail) fail_seen++;
    if (cmp_en) begin
      exp_row = ~(4'b0001 << ((m_k / SD) % 4));
      checkOutput("row", {28'd0, row}, {28'd0, exp_row});
      checkOutput("success", {31'd0, success}, {31'd0, e_success});
      checkOutput("locked", {31'd0, locked}, {31'd0, e_locked});
      checkOutput("fail", {31'd0, fail}, {31'd0, e_fail});
      checkOutput("digits", {16'd0, digits}, {16'd0, digitsOf()});
      checkOutput("count", {29'd0, count}, 32'(m_q.size()));
      checkOutput("tries_left", {30'd0, tries_left}, 32'(e_tries));
    end
  end

  task automatic applyStimulus(input logic [15:0] mask, input int hold_frames);
    keys = mask;
    repeat (hold_frames * FRAME) @(negedge clk);
    keys = '0;
    repeat (2 * FRAME) @(negedge clk);
  endtask

  task automatic pressKey(input int k);
    applyStimulus(16'(1 << k), 5);
  endtask

  task automatic enterCode(input logic [15:0] code);
    pressKey(int'(code[15:12]));
    pressKey(int'(code[11:8]));
    pressKey(int'(code[7:4]));
    pressKey(int'(code[3:0]));
    pressKey(11);
  endtask

  task automatic doReset(input logic arm);
    @(negedge clk);
    #2 rst = 1'b1; armed = 1'b0; expired = 1'b0; keys = '0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0; armed = arm;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    bit got;
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    #2 rst = 1'b0; armed = 1'b1;

    // Correct code on first try
    enterCode(16'h0000 | SECRET);
    checkOutput("s1_digits", {16'd0, digits}, 32'h2468);
    checkOutput("s1_count", {29'd0, count}, 32'd4);
    checkOutput("s1_success", {31'd0, success}, 32'd1);
    checkOutput("s1_locked", {31'd0, locked}, 32'd0);

    // Three wrong codes lock the bomb
    doReset(1'b1);
    base = fail_seen;
    enterCode(16'h1234);
    checkOutput("s2_tries1", {30'd0, tries_left}, 32'd2);
    enterCode(16'h1234);
    enterCode(16'h1234);
    checkOutput("s2_tries3", {30'd0, tries_left}, 32'd0);
    checkOutput("s2_locked", {31'd0, locked}, 32'd1);
    checkOutput("s2_fail_pulses", 32'(fail_seen - base), 32'd3);
    enterCode(SECRET);
    checkOutput("s2_no_success", {31'd0, success}, 32'd0);

    // Clear, then overflow digit ignored
    doReset(1'b1);
    pressKey(2); pressKey(4);
    checkOutput("s3_count2", {29'd0, count}, 32'd2);
    pressKey(10);
    checkOutput("s3_count0", {29'd0, count}, 32'd0);
    pressKey(2); pressKey(4); pressKey(6); pressKey(8); pressKey(9);
    checkOutput("s3_count4", {29'd0, count}, 32'd4);
    checkOutput("s3_digits", {16'd0, digits}, 32'h2468);
    pressKey(11);
    checkOutput("s3_success", {31'd0, success}, 32'd1);

    // Bounce and multi-key frames produce no events
    doReset(1'b1);
    for (int i = 0; i < 8; i++) begin
      keys = 16'(1 << 5);
      repeat (FRAME) @(negedge clk);
      keys = '0;
      repeat (FRAME) @(negedge clk);
    end
    applyStimulus(16'h0044, 5);
    applyStimulus(16'h0006, 5);
    checkOutput("s4_count", {29'd0, count}, 32'd0);
    checkOutput("s4_digits", {16'd0, digits}, 32'd0);

    // Expired wins over a same-cycle correct ENTER
    doReset(1'b1);
    pressKey(2); pressKey(4); pressKey(6); pressKey(8);
    keys = 16'(1 << 11);
    got = 1'b0;
    for (int i = 0; i < 8 * FRAME; i++) begin
      @(negedge clk);
      if (m_pend && m_pcode == 11) begin
        expired = 1'b1;
        got = 1'b1;
        break;
      end
    end
    checkOutput("s5_enter_event", {31'd0, got}, 32'd1);
    repeat (FRAME) @(negedge clk);
    keys = '0;
    repeat (2 * FRAME) @(negedge clk);
    checkOutput("s5_locked", {31'd0, locked}, 32'd1);
    checkOutput("s5_success", {31'd0, success}, 32'd0);

    // Reset mid-entry, then IDLE ignores keys until armed
    doReset(1'b1);
    pressKey(1); pressKey(2); pressKey(3);
    checkOutput("s6_count3", {29'd0, count}, 32'd3);
    checkOutput("s6_digits3", {16'd0, digits}, 32'h0123);
    @(negedge clk);
    #2 rst = 1'b1; armed = 1'b0;
    @(negedge clk);
    checkOutput("s6_rst_count", {29'd0, count}, 32'd0);
    checkOutput("s6_rst_digits", {16'd0, digits}, 32'd0);
    checkOutput("s6_rst_row", {28'd0, row}, 32'he);
    checkOutput("s6_rst_tries", {30'd0, tries_left}, 32'd3);
    #2 rst = 1'b0;
    pressKey(5);
    checkOutput("s6_idle_ignored", {29'd0, count}, 32'd0);
    armed = 1'b1;
    pressKey(7);
    checkOutput("s6_entry_count", {29'd0, count}, 32'd1);

    // Dropping armed returns to IDLE and restores tries
    doReset(1'b1);
    enterCode(16'h1111);
    checkOutput("s7_tries2", {30'd0, tries_left}, 32'd2);
    pressKey(2); pressKey(4);
    armed = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("s7_count", {29'd0, count}, 32'd0);
    checkOutput("s7_digits", {16'd0, digits}, 32'd0);
    checkOutput("s7_tries", {30'd0, tries_left}, 32'd3);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
